// File: rtl/sdp_ram_be_clr.sv
// sdp_ram_be_clr
// Simple-dual-port RAM (one write port, one read port, one clock) with
// byte-lane write enables, a read enable with valid strobe, a 1- or 2-cycle
// read latency, a selectable read/write collision policy and a hardware
// clear engine that zeroes the whole array after reset or on request.
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset; restarts the clear sweep
//   i_clr     one-cycle pulse requesting a clear sweep (honoured in IDLE only)
//   o_busy    clear sweep in progress, user reads/writes are not accepted
//   i_wren    write enable
//   i_wbe     byte-lane enables, lane k covers bits [k*BYTE_W +: BYTE_W]
//   i_waddr   write address (out-of-range writes are dropped)
//   i_wdata   write data
//   i_rden    read enable
//   i_raddr   read address (out-of-range reads return zero)
//   o_rdata   read data, holds its last value while o_rvalid is low
//   o_rvalid  one-cycle strobe per accepted read
//
// DATA_W must be a multiple of BYTE_W; RD_LAT must be 1 or 2.

module sdp_ram_be_clr #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int BYTE_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0,
    parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NBE      = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic              i_wren,
    input  logic [NBE-1:0]    i_wbe,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rden,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    // One extra bit so DEPTH itself is representable for the range checks.
    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clrCnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_ramData;
    logic                r_v1;
    logic                r_oor1;
    logic                r_byp1;
    logic [DATA_W-1:0]   r_bypData;
    logic [NBE-1:0]      r_bypBe;

    logic                w_busy;
    logic                w_wrAcc;
    logic                w_rdAcc;
    logic                w_rdOor;
    logic                w_coll;
    logic                w_clrWe;
    logic [DATA_W-1:0]   w_merged;

    // The array is only usable in IDLE; rst also blocks acceptance so that a
    // reset edge never lets a user access slip through.
    assign w_busy  = (r_state == S_CLEAR);
    assign o_busy  = w_busy;
    assign w_wrAcc = i_wren && !w_busy && !rst && ({1'b0, i_waddr} < L_DEPTH);
    assign w_rdAcc = i_rden && !w_busy && !rst;
    assign w_rdOor = !({1'b0, i_raddr} < L_DEPTH);
    assign w_coll  = w_rdAcc && w_wrAcc && (i_raddr == i_waddr);
    assign w_clrWe = w_busy && !rst;

    // Clear engine: walks the counter from 0 to DEPTH-1, one word per cycle,
    // then drops to IDLE. A clear request is only looked at in IDLE, so a
    // pulse arriving mid-sweep cannot stretch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLEAR;
            r_clrCnt <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clrCnt == L_LAST) begin
                        r_state  <= S_IDLE;
                        r_clrCnt <= '0;
                    end else begin
                        r_clrCnt <= r_clrCnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_clr) begin
                        r_state  <= S_CLEAR;
                        r_clrCnt <= '0;
                    end
                end
            endcase
        end
    end

    // Storage array plus its read register. The array itself has no reset so
    // it maps onto block RAM; the sweep is the only thing that zeroes it.
    // Reading with a non-blocking assignment gives read-first behaviour on
    // a same-address collision, which the bypass below can override.
    always_ff @(posedge clk) begin
        if (w_clrWe) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_wrAcc) begin
            for (int k = 0; k < NBE; k++) begin
                if (i_wbe[k]) begin
                    r_mem[i_waddr][k*BYTE_W +: BYTE_W] <= i_wdata[k*BYTE_W +: BYTE_W];
                end
            end
        end
        if (rst) begin
            r_ramData <= '0;
        end else if (w_rdAcc && !w_rdOor) begin
            r_ramData <= r_mem[i_raddr];
        end
    end

    // Side-band information travelling alongside the RAM read: valid, the
    // out-of-range flag and, for write-first, the colliding write's data and
    // lanes. These only load on an accepted read so the output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_oor1    <= 1'b0;
            r_byp1    <= 1'b0;
            r_bypData <= '0;
            r_bypBe   <= '0;
        end else begin
            r_v1 <= w_rdAcc;
            if (w_rdAcc) begin
                r_oor1    <= w_rdOor;
                r_byp1    <= (WR_FIRST != 0) && w_coll;
                r_bypData <= i_wdata;
                r_bypBe   <= i_wbe;
            end
        end
    end

    // Merge the colliding write's enabled lanes over the old word, and force
    // zero for addresses beyond the array.
    always_comb begin
        w_merged = r_ramData;
        for (int k = 0; k < NBE; k++) begin
            if (r_byp1 && r_bypBe[k]) begin
                w_merged[k*BYTE_W +: BYTE_W] = r_bypData[k*BYTE_W +: BYTE_W];
            end
        end
        if (r_oor1) begin
            w_merged = '0;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_out;
            logic              r_v2;

            // Extra output register; loads only when a result arrives so the
            // data holds between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= '0;
                    r_v2  <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_out <= w_merged;
                    end
                end
            end

            assign o_rdata  = r_out;
            assign o_rvalid = r_v2;
        end else begin : g_lat1
            assign o_rdata  = w_merged;
            assign o_rvalid = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_be_clr.sv
// Testbench for sdp_ram_be_clr. Two instances share all inputs:
//   uA: DEPTH=6 (non power of two), RD_LAT=1, read-first collisions
//   uB: DEPTH=8, RD_LAT=2, write-first collisions
// Both have a 3-bit address, so address 7 is out of range for uA only.

module tb_sdp_ram_be_clr;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        wren;
   logic        rden;
   logic [3:0]  wbe;
   logic [2:0]  waddr;
   logic [2:0]  raddr;
   logic [31:0] wdata;

   logic        busyA, rvalidA, busyB, rvalidB;
   logic [31:0] rdataA, rdataB;

   int testCount = 0;
   int failCount = 0;
   int cntA;
   int cntB;

   // Final expected contents after all directed writes.
   logic [31:0] finalA [8] = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'hAA22CC44,
                               32'h00000000, 32'h1234FFFF, 32'h00000000, 32'h00000000};
   logic [31:0] finalB [8] = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'hAA22CC44,
                               32'h00000000, 32'h1234FFFF, 32'h00000000, 32'h00000055};

   always #5 clk = ~clk;

   sdp_ram_be_clr #(.DATA_W(32), .DEPTH(6), .BYTE_W(8), .RD_LAT(1), .WR_FIRST(0)) uA (
      .clk(clk), .rst(rst), .i_clr(clr), .o_busy(busyA),
      .i_wren(wren), .i_wbe(wbe), .i_waddr(waddr), .i_wdata(wdata),
      .i_rden(rden), .i_raddr(raddr), .o_rdata(rdataA), .o_rvalid(rvalidA)
   );

   sdp_ram_be_clr #(.DATA_W(32), .DEPTH(8), .BYTE_W(8), .RD_LAT(2), .WR_FIRST(1)) uB (
      .clk(clk), .rst(rst), .i_clr(clr), .o_busy(busyB),
      .i_wren(wren), .i_wbe(wbe), .i_waddr(waddr), .i_wdata(wdata),
      .i_rden(rden), .i_raddr(raddr), .o_rdata(rdataB), .o_rvalid(rvalidB)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; everything is driven and sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle's worth of port values and let an edge sample them.
   task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [2:0] wa,
                                input logic [31:0] wd, input logic re, input logic [2:0] ra);
      wren  = we;
      wbe   = be;
      waddr = wa;
      wdata = wd;
      rden  = re;
      raddr = ra;
      tick();
   endtask

   // Single read (optionally with a same-cycle write to the same address),
   // checking the 1-cycle result on uA and the 2-cycle result on uB.
   task automatic readBoth(input string tag, input logic [2:0] addr,
                           input logic [31:0] expA, input logic [31:0] expB,
                           input logic we, input logic [3:0] be, input logic [31:0] wd);
      applyStimulus(we, be, addr, wd, 1'b1, addr);
      checkOutput({tag, ".vA"}, 32'(rvalidA), 32'd1);
      checkOutput({tag, ".dA"}, rdataA, expA);
      checkOutput({tag, ".vBearly"}, 32'(rvalidB), 32'd0);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
      checkOutput({tag, ".vB"}, 32'(rvalidB), 32'd1);
      checkOutput({tag, ".dB"}, rdataB, expB);
      checkOutput({tag, ".vAoff"}, 32'(rvalidA), 32'd0);
      checkOutput({tag, ".dAhold"}, rdataA, expA);
   endtask

   task automatic writeWord(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
      applyStimulus(1'b1, be, addr, data, 1'b0, 3'd0);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      wren = 1'b0; rden = 1'b0; wbe = 4'h0; waddr = 3'd0; raddr = 3'd0; wdata = 32'h0;

      // Two reset cycles, then check reset outputs.
      tick();
      tick();
      checkOutput("rst.busyA", 32'(busyA), 32'd1);
      checkOutput("rst.busyB", 32'(busyB), 32'd1);
      checkOutput("rst.vA", 32'(rvalidA), 32'd0);
      checkOutput("rst.dA", rdataA, 32'h0);
      checkOutput("rst.vB", 32'(rvalidB), 32'd0);
      checkOutput("rst.dB", rdataB, 32'h0);
      rst = 1'b0;

      // Power-up sweep: measure busy length, write to an already-cleared
      // address while busy (must be dropped), and pulse clr on uA's last
      // sweep cycle / mid-sweep for uB (must be ignored).
      cntA = 0;
      cntB = 0;
      for (int i = 0; i < 20; i++) begin
         if (busyA) cntA++;
         if (busyB) cntB++;
         wren  = (i == 3);
         wbe   = 4'hF;
         waddr = 3'd0;
         wdata = 32'hDEADBEEF;
         clr   = (i == 5);
         tick();
      end
      wren = 1'b0;
      clr  = 1'b0;
      checkOutput("sweep.lenA", 32'(cntA), 32'd6);
      checkOutput("sweep.lenB", 32'(cntB), 32'd8);

      // Every address reads zero after the sweep, including out-of-range ones.
      for (int a = 0; a < 8; a++) begin
         readBoth($sformatf("zero%0d", a), 3'(a), 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      end

      // Byte lanes.
      writeWord(3'd3, 32'hAABBCCDD, 4'b1111);
      writeWord(3'd3, 32'h11223344, 4'b0101);
      readBoth("lanes", 3'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 4'h0, 32'h0);
      writeWord(3'd3, 32'h00000000, 4'b0000);
      readBoth("beZero", 3'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 4'h0, 32'h0);

      // Collision: read-first on uA, write-first merge on uB.
      writeWord(3'd5, 32'h12345678, 4'b1111);
      readBoth("coll", 3'd5, 32'h12345678, 32'h1234FFFF, 1'b1, 4'b0011, 32'hFFFFFFFF);
      readBoth("postColl", 3'd5, 32'h1234FFFF, 32'h1234FFFF, 1'b0, 4'h0, 32'h0);

      // Address 7: out of range for uA (dropped, reads 0), in range for uB.
      writeWord(3'd7, 32'h00000055, 4'b1111);
      readBoth("oor7", 3'd7, 32'h0, 32'h00000055, 1'b0, 4'h0, 32'h0);

      writeWord(3'd0, 32'h000000A0, 4'b1111);
      writeWord(3'd1, 32'h000000A1, 4'b1111);
      writeWord(3'd2, 32'h000000A2, 4'b1111);
      for (int a = 0; a < 8; a++) begin
         readBoth($sformatf("scan%0d", a), 3'(a), finalA[a], finalB[a], 1'b0, 4'h0, 32'h0);
      end

      // Back-to-back reads of 0,1,2.
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd0);
      checkOutput("tp1.vA", 32'(rvalidA), 32'd1);
      checkOutput("tp1.dA", rdataA, 32'h000000A0);
      checkOutput("tp1.vB", 32'(rvalidB), 32'd0);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd1);
      checkOutput("tp2.dA", rdataA, 32'h000000A1);
      checkOutput("tp2.vB", 32'(rvalidB), 32'd1);
      checkOutput("tp2.dB", rdataB, 32'h000000A0);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd2);
      checkOutput("tp3.dA", rdataA, 32'h000000A2);
      checkOutput("tp3.vB", 32'(rvalidB), 32'd1);
      checkOutput("tp3.dB", rdataB, 32'h000000A1);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
      checkOutput("tp4.vA", 32'(rvalidA), 32'd0);
      checkOutput("tp4.vB", 32'(rvalidB), 32'd1);
      checkOutput("tp4.dB", rdataB, 32'h000000A2);
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
      checkOutput("tp5.vB", 32'(rvalidB), 32'd0);
      checkOutput("tp5.dBhold", rdataB, 32'h000000A2);

      // Clear request together with a read on the last IDLE cycle.
      clr = 1'b1;
      applyStimulus(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd3);
      clr  = 1'b0;
      rden = 1'b0;
      cntA = 0;
      cntB = 0;
      for (int i = 0; i < 20; i++) begin
         if (busyA) cntA++;
         if (busyB) cntB++;
         if (i == 0) begin
            checkOutput("clr.busyRise", 32'(busyB), 32'd1);
            checkOutput("clr.vA", 32'(rvalidA), 32'd1);
            checkOutput("clr.dA", rdataA, 32'hAA22CC44);
         end
         if (i == 1) begin
            checkOutput("clr.vB", 32'(rvalidB), 32'd1);
            checkOutput("clr.dB", rdataB, 32'hAA22CC44);
         end
         tick();
      end
      checkOutput("clr.lenA", 32'(cntA), 32'd6);
      checkOutput("clr.lenB", 32'(cntB), 32'd8);
      readBoth("afterClr", 3'd3, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);

      // Reset while the sweep is at address 4 restarts a full sweep.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
      tick();
      tick();
      checkOutput("midRst.busyB", 32'(busyB), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cntA = 0;
      cntB = 0;
      for (int i = 0; i < 20; i++) begin
         if (busyA) cntA++;
         if (busyB) cntB++;
         tick();
      end
      checkOutput("rstSweep.lenA", 32'(cntA), 32'd6);
      checkOutput("rstSweep.lenB", 32'(cntB), 32'd8);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
